// File: rtl/arm_pipelined_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : arm_pipelined_fetch_unit
// Brief   : ARM instruction fetch with a credit-limited prefetch FIFO and
//           branch redirect. Optional macro ARM_FETCH_PERF_CNT_EN adds
//           o_StallCycles.
// Revision: 1.0 - initial release
// ============================================================================
module arm_pipelined_fetch_unit #(
    parameter int BUS_WIDTH  = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 i_CLK,
    input  logic                 i_NRESET,
    output logic                 o_IMemReq,
    output logic [BUS_WIDTH-1:0] o_IMemAddr,
    input  logic                 i_IMemReady,
    input  logic                 i_IMemRValid,
    input  logic [BUS_WIDTH-1:0] i_IMemRData,
    input  logic                 i_BranchTaken,
    input  logic [BUS_WIDTH-1:0] i_BranchTarget,
    input  logic                 i_DecodeStall,
    output logic                 o_InstrValid,
    output logic [BUS_WIDTH-1:0] o_Instr,
    output logic [BUS_WIDTH-1:0] o_PCPlus8
`ifdef ARM_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          o_StallCycles
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [BUS_WIDTH-1:0] fetch_pc;
    logic [BUS_WIDTH-1:0] issued_pc;
    logic [BUS_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0] fifo_pc8   [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 redirect;
    logic                 unused_target_bits;

    assign redirect           = i_BranchTaken;
    assign accept             = o_IMemReq && i_IMemReady;
    // Responses only count in S_WAIT; anything else is stale or unsolicited.
    assign push               = (state == S_WAIT) && i_IMemRValid && !redirect;
    assign pop                = o_InstrValid && !i_DecodeStall && !redirect;
    assign unused_target_bits = ^i_BranchTarget[1:0];

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ:   if (accept) state_next = redirect ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (i_IMemRValid)  state_next = S_REQ;
                else if (redirect) state_next = S_DRAIN;
            end
            // A response arriving here retires the only outstanding request.
            S_DRAIN: if (i_IMemRValid) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_IMemReq = 1'b0;
        if (state == S_REQ && count < CNT_W'(FIFO_DEPTH)) begin
            o_IMemReq = 1'b1;
        end
    end

    assign o_IMemAddr = fetch_pc;

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            fetch_pc  <= '0;
            issued_pc <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= {i_BranchTarget[BUS_WIDTH-1:2], 2'b00};
            end else if (accept) begin
                fetch_pc <= fetch_pc + BUS_WIDTH'(4);
            end
            if (accept) begin
                issued_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc8[i]   <= '0;
            end
        end else if (push) begin
            fifo_instr[wr_ptr] <= i_IMemRData;
            fifo_pc8[wr_ptr]   <= issued_pc + BUS_WIDTH'(8);
        end
    end

    assign o_InstrValid = (count != '0);
    assign o_Instr      = fifo_instr[rd_ptr];
    assign o_PCPlus8    = fifo_pc8[rd_ptr];

`ifdef ARM_FETCH_PERF_CNT_EN
    logic stall_event;
    assign stall_event = (o_IMemReq && !i_IMemReady) ||
                         ((state == S_WAIT || state == S_DRAIN) && !i_IMemRValid);

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            o_StallCycles <= '0;
        end else if (stall_event && o_StallCycles != 32'hFFFF_FFFF) begin
            o_StallCycles <= o_StallCycles + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire
